// File: rtl/diff_rr_scheduler_if.sv
// Bundles the per-channel sample inputs and the single result output of diff_rr_scheduler.
// Valid/ready contract: a beat transfers on a rising clk edge when valid & ready are both high; a producer never withdraws valid on the basis of ready.
interface diff_rr_scheduler_if #(
  parameter int word_size = 8,
  parameter int num_ch    = 4
);
  localparam int CW = $clog2(num_ch);

  logic [num_ch-1:0]           in_valid;
  logic [num_ch*word_size-1:0] in_data;
  logic [num_ch-1:0]           in_ready;
  logic [num_ch-1:0]           ch_clear;
  logic                        out_valid;
  logic [word_size-1:0]        out_data;
  logic [CW-1:0]               out_ch;
  logic                        out_first;
  logic                        out_ready;

  modport master (
    output in_valid, in_data, ch_clear, out_ready,
    input  in_ready, out_valid, out_data, out_ch, out_first
  );

  modport slave (
    input  in_valid, in_data, ch_clear, out_ready,
    output in_ready, out_valid, out_data, out_ch, out_first
  );
endinterface

// File: rtl/diff_rr_scheduler.sv
// Round-robin scheduler that picks one channel per cycle and emits the first difference
// between its new sample and that channel's previous sample through a one-deep output register.
module diff_rr_scheduler #(
  parameter int word_size = 8,
  parameter int num_ch    = 4
) (
  input logic               clk,
  input logic               rst,
  diff_rr_scheduler_if.slave bus
);
  localparam int CW = $clog2(num_ch);

  logic [word_size-1:0] hist_q [num_ch];
  logic [num_ch-1:0]    primed_q;
  logic [CW-1:0]        rr_ptr_q;
  logic                 out_valid_q;
  logic [word_size-1:0] out_data_q;
  logic [CW-1:0]        out_ch_q;
  logic                 out_first_q;

  logic [num_ch-1:0]    eligible;
  logic                 can_accept;
  logic                 grant_found;
  logic [CW-1:0]        grant_idx;
  logic                 accept;
  logic [num_ch-1:0]    ready_d;
  logic [word_size-1:0] sel_data;
  logic [word_size-1:0] diff_d;
  logic [CW-1:0]        rr_ptr_d;
  int                   idx;

  assign eligible   = bus.in_valid & ~bus.ch_clear;
  assign can_accept = !out_valid_q || bus.out_ready;

  // Scan from the far end back toward rr_ptr so the channel nearest rr_ptr wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = num_ch - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr_q) + k) % num_ch;
      if (eligible[idx]) begin
        grant_found = 1'b1;
        grant_idx   = CW'(idx);
      end
    end
  end

  // rst gates the strobe so no upstream beat is consumed while the block is held in reset.
  assign accept = grant_found && can_accept && !rst;

  always_comb begin
    ready_d = '0;
    if (accept) ready_d[grant_idx] = 1'b1;
  end

  assign sel_data = bus.in_data[grant_idx*word_size +: word_size];
  assign diff_d   = sel_data - hist_q[grant_idx];
  assign rr_ptr_d = CW'((int'(grant_idx) + 1) % num_ch);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < num_ch; i++) hist_q[i] <= '0;
      primed_q    <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_first_q <= 1'b0;
    end else begin
      // A cleared channel is never eligible, so its clear cannot collide with the accept below.
      for (int i = 0; i < num_ch; i++) begin
        if (bus.ch_clear[i]) begin
          hist_q[i]   <= '0;
          primed_q[i] <= 1'b0;
        end
      end
      if (accept) begin
        hist_q[grant_idx]   <= sel_data;
        primed_q[grant_idx] <= 1'b1;
        rr_ptr_q            <= rr_ptr_d;
        out_valid_q         <= 1'b1;
        out_data_q          <= diff_d;
        out_ch_q            <= grant_idx;
        out_first_q         <= !primed_q[grant_idx];
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = ready_d;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_first = out_first_q;
endmodule

// File: tb/tb_diff_rr_scheduler.sv
// Bench for diff_rr_scheduler: fixed vector table, hand-written corner sequences and a
// randomized run, all compared against a behavioural model of the scheduler.
module tb_diff_rr_scheduler;
  localparam int WS = 8;
  localparam int NC = 4;

  logic clk;
  logic rst;
  diff_rr_scheduler_if #(.word_size(WS), .num_ch(NC)) bus ();

  diff_rr_scheduler #(.word_size(WS), .num_ch(NC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  int m_hist [NC];
  bit m_primed [NC];
  int m_ptr;
  bit m_ovalid;
  int m_odata;
  int m_och;
  bit m_ofirst;

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      m_hist[i]   = 0;
      m_primed[i] = 0;
    end
    m_ptr = 0; m_ovalid = 0; m_odata = 0; m_och = 0; m_ofirst = 0;
  endtask

  // Returns the channel that should win this cycle, or -1 when nothing may be accepted.
  function automatic int model_grant(logic [NC-1:0] iv, logic [NC-1:0] clr, logic ordy);
    if (m_ovalid && !ordy) return -1;
    for (int k = 0; k < NC; k++) begin
      int c;
      c = (m_ptr + k) % NC;
      if (iv[c] && !clr[c]) return c;
    end
    return -1;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Called right after a falling edge; returns the in_ready seen before the next rising edge.
  task automatic apply(input logic [NC-1:0] iv, input logic [NC*WS-1:0] id,
                       input logic [NC-1:0] clr, input logic ordy,
                       output logic [NC-1:0] seen_ready);
    int g;
    logic [NC-1:0] exp_ready;
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.ch_clear  = clr;
    bus.out_ready = ordy;
    #1;
    g = model_grant(iv, clr, ordy);
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    seen_ready = bus.in_ready;
    chk("in_ready", int'(bus.in_ready), int'(exp_ready));
    @(posedge clk);
    if (g >= 0) begin
      int smp;
      smp      = int'(id[g*WS +: WS]);
      m_odata  = (smp - m_hist[g]) & 8'hFF;
      m_och    = g;
      m_ofirst = !m_primed[g];
      m_ovalid = 1;
      m_hist[g]   = smp;
      m_primed[g] = 1;
      m_ptr = (g + 1) % NC;
    end else if (ordy) begin
      m_ovalid = 0;
    end
    for (int i = 0; i < NC; i++) begin
      if (clr[i]) begin
        m_hist[i] = 0;
        m_primed[i] = 0;
      end
    end
    #1;
    chk("out_valid", int'(bus.out_valid), int'(m_ovalid));
    chk("out_data",  int'(bus.out_data),  m_odata);
    chk("out_ch",    int'(bus.out_ch),    m_och);
    chk("out_first", int'(bus.out_first), int'(m_ofirst));
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [NC-1:0]    iv;
    logic [NC*WS-1:0] id;
    logic [NC-1:0]    clr;
    logic             ordy;
    logic [NC-1:0]    e_ready;
    logic             e_valid;
    logic [WS-1:0]    e_data;
    int               e_ch;
    logic             e_first;
  } vec_t;

  vec_t vt [$];
  logic [NC-1:0] rdy;

  function automatic logic [NC*WS-1:0] pk(int d3, int d2, int d1, int d0);
    return {WS'(d3), WS'(d2), WS'(d1), WS'(d0)};
  endfunction

  initial begin
    rst = 1'b0;
    bus.in_valid = '0; bus.in_data = '0; bus.ch_clear = '0; bus.out_ready = 1'b0;
    model_reset();

    // Ch0 stream, ch3 wraparound difference, ch1 clear, backpressure, full contention.
    vt.push_back('{4'b0001, pk(0,0,0,10),   4'b0000, 1'b1, 4'b0001, 1'b1, 8'd10,  0, 1'b1});
    vt.push_back('{4'b0001, pk(0,0,0,15),   4'b0000, 1'b1, 4'b0001, 1'b1, 8'd5,   0, 1'b0});
    vt.push_back('{4'b0001, pk(0,0,0,12),   4'b0000, 1'b1, 4'b0001, 1'b1, 8'd253, 0, 1'b0});
    vt.push_back('{4'b0000, pk(0,0,0,0),    4'b0000, 1'b1, 4'b0000, 1'b0, 8'd253, 0, 1'b0});
    vt.push_back('{4'b1000, pk(5,0,0,0),    4'b0000, 1'b1, 4'b1000, 1'b1, 8'd5,   3, 1'b1});
    vt.push_back('{4'b1000, pk(2,0,0,0),    4'b0000, 1'b1, 4'b1000, 1'b1, 8'hFD,  3, 1'b0});
    vt.push_back('{4'b0010, pk(0,0,40,0),   4'b0000, 1'b1, 4'b0010, 1'b1, 8'd40,  1, 1'b1});
    vt.push_back('{4'b0010, pk(0,0,99,0),   4'b0010, 1'b1, 4'b0000, 1'b0, 8'd40,  1, 1'b1});
    vt.push_back('{4'b0010, pk(0,0,7,0),    4'b0000, 1'b1, 4'b0010, 1'b1, 8'd7,   1, 1'b1});
    vt.push_back('{4'b0001, pk(0,0,0,50),   4'b0000, 1'b0, 4'b0000, 1'b1, 8'd7,   1, 1'b1});
    vt.push_back('{4'b0001, pk(0,0,0,50),   4'b0000, 1'b0, 4'b0000, 1'b1, 8'd7,   1, 1'b1});
    vt.push_back('{4'b0001, pk(0,0,0,50),   4'b0000, 1'b0, 4'b0000, 1'b1, 8'd7,   1, 1'b1});
    vt.push_back('{4'b0001, pk(0,0,0,50),   4'b0000, 1'b1, 4'b0001, 1'b1, 8'd38,  0, 1'b0});
    vt.push_back('{4'b1111, pk(4,3,2,1),    4'b0000, 1'b1, 4'b0010, 1'b1, 8'd251, 1, 1'b0});
    vt.push_back('{4'b1111, pk(4,3,2,1),    4'b0000, 1'b1, 4'b0100, 1'b1, 8'd3,   2, 1'b1});
    vt.push_back('{4'b1111, pk(4,3,2,1),    4'b0000, 1'b1, 4'b1000, 1'b1, 8'd2,   3, 1'b0});
    vt.push_back('{4'b1111, pk(4,3,2,1),    4'b0000, 1'b1, 4'b0001, 1'b1, 8'd207, 0, 1'b0});

    // Reset values, including in_ready held low while rst is high with requests pending.
    #2;
    rst = 1'b1;
    bus.in_valid = 4'b1111;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready",  int'(bus.in_ready),  0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_data",  int'(bus.out_data),  0);
    chk("rst_out_ch",    int'(bus.out_ch),    0);
    chk("rst_out_first", int'(bus.out_first), 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vt[i]) begin
      apply(vt[i].iv, vt[i].id, vt[i].clr, vt[i].ordy, rdy);
      chk($sformatf("vec%0d_ready", i), int'(rdy), int'(vt[i].e_ready));
      chk($sformatf("vec%0d_valid", i), int'(bus.out_valid), int'(vt[i].e_valid));
      chk($sformatf("vec%0d_data",  i), int'(bus.out_data),  int'(vt[i].e_data));
      chk($sformatf("vec%0d_ch",    i), int'(bus.out_ch),    vt[i].e_ch);
      chk($sformatf("vec%0d_first", i), int'(bus.out_first), int'(vt[i].e_first));
    end

    // Asynchronous reset with a result pending: output clears with no clock edge.
    apply(4'b0001, pk(0,0,0,77), 4'b0000, 1'b0, rdy);
    chk("pend_valid", int'(bus.out_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_out_valid", int'(bus.out_valid), 0);
    chk("async_out_data",  int'(bus.out_data),  0);
    chk("async_in_ready",  int'(bus.in_ready),  0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    apply(4'b0100, pk(0,9,0,0), 4'b0000, 1'b1, rdy);
    chk("post_rst_ready", int'(rdy), 4'b0100);
    chk("post_rst_data",  int'(bus.out_data),  9);
    chk("post_rst_first", int'(bus.out_first), 1);
    chk("post_rst_ch",    int'(bus.out_ch),    2);

    // Full contention right after reset: grants rotate from channel 0.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      logic [NC-1:0] onehot;
      onehot = '0;
      onehot[i % NC] = 1'b1;
      apply(4'b1111, pk(40,30,20,10), 4'b0000, 1'b1, rdy);
      chk($sformatf("rot%0d_ready", i), int'(rdy), int'(onehot));
    end

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      logic [NC-1:0] clr;
      clr = ($urandom_range(0, 5) == 0) ? NC'($urandom_range(0, 15)) : '0;
      if ($urandom_range(0, 99) == 0) do_reset();
      apply(NC'($urandom_range(0, 15)), {$urandom()}, clr,
            ($urandom_range(0, 3) != 0), rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/diff_rr_scheduler.md
DIFF_RR_SCHEDULER -- requirements
Module: diff_rr_scheduler

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Parameter: word_size, default 8, sample and difference width in bits.
REQ-003 Parameter: num_ch, default 4, number of requesting channels (>=2); CW = clog2(num_ch).
REQ-004 Port: clk  input  1  rising-edge clock for all state.
REQ-005 Port: rst  input  1  asynchronous active-high reset.
REQ-006 Port: in_valid  input  num_ch  per-channel sample-valid.
REQ-007 Port: in_data  input  num_ch*word_size  channel i sample at bits [i*word_size +: word_size].
REQ-008 Port: in_ready  output  num_ch  per-channel accept strobe; transfer when in_valid[i] & in_ready[i].
REQ-009 Port: ch_clear  input  num_ch  per-channel history clear request.
REQ-010 Port: out_valid  output  1  output register holds a result.
REQ-011 Port: out_data  output  word_size  first difference for out_ch.
REQ-012 Port: out_ch  output  CW  channel index of out_data.
REQ-013 Port: out_first  output  1  result is the first sample since reset or clear for out_ch.
REQ-014 Port: out_ready  input  1  downstream accept; transfer when out_valid & out_ready.

Function
REQ-015 State SHALL be: hist[num_ch] (word_size each), primed[num_ch], rr_ptr (CW), output register (out_valid, out_data, out_ch, out_first).
REQ-016 can_accept SHALL equal !out_valid | out_ready.
REQ-017 Eligible channel i: in_valid[i] & !ch_clear[i].
REQ-018 Grant g SHALL be the first eligible channel found scanning rr_ptr, rr_ptr+1, ... modulo num_ch; no grant if none eligible.
REQ-019 in_ready SHALL be one-hot at bit g when can_accept and a grant exists, else all zero; in_ready is combinational from current inputs and state.
REQ-020 On accept of channel g: out_data <= (in_data[g] - hist[g]) mod 2^word_size; out_ch <= g; out_first <= !primed[g]; out_valid <= 1; hist[g] <= in_data[g]; primed[g] <= 1; rr_ptr <= (g+1) mod num_ch.
REQ-021 Latency SHALL be one cycle from accept to out_valid; throughput one result per cycle under continuous out_ready.
REQ-022 When out_valid & !out_ready, out_valid, out_data, out_ch, out_first SHALL hold stable and no channel SHALL be accepted.
REQ-023 When out_valid & out_ready and no accept occurs, out_valid SHALL go 0 next cycle; with a simultaneous accept, out_valid stays 1 and the new result loads.
REQ-024 With no accept, rr_ptr SHALL hold.
REQ-025 ch_clear[i] SHALL set hist[i] <= 0 and primed[i] <= 0 next edge, block channel i that cycle, and not affect the output register or other channels.
REQ-026 Unprimed history is 0, so a first sample's out_data SHALL equal the sample itself.
REQ-027 Subtraction SHALL wrap modulo 2^word_size with no saturation or overflow flag.

Reset
REQ-028 Asserting rst SHALL immediately force out_valid=0, out_data=0, out_ch=0, out_first=0, rr_ptr=0, all hist=0, all primed=0.
REQ-029 in_ready SHALL be all zero while rst is high.
REQ-030 A result pending in the output register at reset SHALL be discarded.

Verification (word_size=8, num_ch=4)
REQ-031 Ch0 only, samples 10,15,12, out_ready=1 -> out_data 10 (out_first=1), 5, 253 (0xFD), out_ch=0, each one cycle after accept.
REQ-032 All in_valid=1 continuously, out_ready=1 -> grants 0,1,2,3,0,1 on consecutive cycles; in_ready always one-hot.
REQ-033 Result pending, out_ready=0 for 3 cycles -> out_valid/out_data/out_ch stable, in_ready=0; out_ready=1 -> drain and next accept same cycle.
REQ-034 ch1 hist=40, ch_clear[1]=1 with in_valid[1]=1 -> ch1 not granted that cycle; next ch1 sample 7 -> out_data 7, out_first=1.
REQ-035 rst pulsed mid-stream with out_valid=1 -> out_valid=0 without a clock edge; after release ch2 sample 9 -> out_data 9, out_first=1, first grant from rr_ptr=0.
REQ-036 Ch3 hist=0x05, sample 0x02 -> out_data 0xFD, out_first=0.
